// File: rtl/uart_tx_con.sv
// UART transmitter with byte FIFO; 8N1 framing, even parity bit added when UART_TX_PARITY_EN is defined.
// Latency: tx falls one clk after a byte is written into an empty FIFO while idle; each bit lasts CLK_FREQ/BAUD clks.
// Backpressure: writes while full are dropped and set the sticky overflow flag; frames run back-to-back while data is buffered.
module uart_tx_con #(
   parameter int CLK_FREQ   = 23000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       clr_ovf,
   output logic       tx,
   output logic       full,
   output logic       busy,
   output logic [6:0] count,
   output logic       overflow
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int BW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
   localparam logic [6:0]    DEPTH     = 7'(FIFO_DEPTH);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd4;
`endif

   logic [2:0]    state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [7:0]    head;
   logic          baud_end;
   logic          empty;
   logic          push;
   logic          pop;
`ifdef UART_TX_PARITY_EN
   logic          par_bit;
`endif

   assign head     = mem[rd_ptr];
   assign baud_end = (baud_cnt == BAUD_LAST);
   assign empty    = (count == 7'd0);
   assign full     = (count == DEPTH);
   assign busy     = (state != IDLE) || !empty;
   assign push     = wr_en && !full;
   // The head is consumed exactly when the FSM (re)enters START.
   assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_end));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= 7'd0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 7'd1;
            2'b01:   count <= count - 7'd1;
            default: count <= count;
         endcase
         // A dropped write wins over a coincident clear.
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= 3'd0;
         shreg    <= 8'd0;
         tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state    <= START;
                  shreg    <= head;
                  tx       <= 1'b0;
                  baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                  par_bit  <= ^head;
`endif
               end
            end
            START: begin
               if (baud_end) begin
                  state    <= DATA;
                  tx       <= shreg[0];
                  shreg    <= {1'b0, shreg[7:1]};
                  bit_cnt  <= 3'd0;
                  baud_cnt <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= par_bit;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_end) begin
                  state    <= STOP;
                  tx       <= 1'b1;
                  baud_cnt <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     state <= START;
                     shreg <= head;
                     tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                     par_bit <= ^head;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               tx       <= 1'b1;
               baud_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_con.sv
// Bench for uart_tx_con: a line monitor decodes tx frames and checks them against a queue of expected bytes.
`timescale 1ns/1ps
module tb_uart_tx_con;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int DIV      = 10;
   localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * DIV;

   logic       clk;
   logic       rstn;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       clr_ovf;
   logic       tx;
   logic       full;
   logic       busy;
   logic [6:0] count;
   logic       overflow;

   int         checks;
   int         failures;
   int         cyc;
   logic [7:0] exp_q[$];
   int         frame_starts[$];

   uart_tx_con #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .clr_ovf (clr_ovf),
      .tx      (tx),
      .full    (full),
      .busy    (busy),
      .count   (count),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check(name, busy, 0);
   endtask

   // Line monitor: samples every cycle on the falling clock edge.
   initial begin : monitor
      logic [10:0] bits;
      logic        glitch;
      logic        aborted;
      logic [7:0]  exp_b;
      int          exp_frame;
      int          start_cyc;
      forever begin
         @(negedge clk);
         if (rstn && tx == 1'b0) begin
            start_cyc = cyc;
            bits      = '0;
            glitch    = 1'b0;
            aborted   = 1'b0;
            for (int j = 0; j < FRAME; j++) begin
               if (j > 0) @(negedge clk);
               if (!rstn) begin
                  aborted = 1'b1;
                  break;
               end
               if (j % DIV == 0) bits[j / DIV] = tx;
               else if (tx != bits[j / DIV]) glitch = 1'b1;
            end
            if (!aborted) begin
               frame_starts.push_back(start_cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_frame: got bits 0x%0h expected no frame", bits);
               end else begin
                  exp_b = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
                  exp_frame = int'({1'b1, ^exp_b, exp_b, 1'b0});
`else
                  exp_frame = int'({1'b1, exp_b, 1'b0});
`endif
                  check("frame_bits", int'(bits), exp_frame);
                  check("bit_hold_div", int'(glitch), 0);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int base;
      logic low_seen;
      checks   = 0;
      failures = 0;
      rstn     = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      clr_ovf  = 1'b0;
      #23;
      check("rst_tx", tx, 1);
      check("rst_full", full, 0);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      tick();
      rstn = 1'b1;
      tick();
      tick();

      // Single byte from idle
      wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
      tick();
      wr_en = 1'b0;
      check("t1_count_after_wr", count, 1);
      check("t1_busy_after_wr", busy, 1);
      check("t1_tx_before_start", tx, 1);
      tick();
      check("t1_tx_start_next_edge", tx, 0);
      check("t1_count_after_pop", count, 0);
      begin
         int n;
         n = 0;
         while (busy && n < 300) begin
            tick();
            n++;
         end
         check("t1_busy_cycles", n, FRAME);
      end
      tick();
      tick();

      // Three back-to-back frames
      base = frame_starts.size();
      wr_en = 1'b1;
      wr_data = 8'h01; exp_q.push_back(8'h01); tick();
      wr_data = 8'h80; exp_q.push_back(8'h80); tick();
      wr_data = 8'hFF; exp_q.push_back(8'hFF); tick();
      wr_en = 1'b0;
      wait_idle("t2_drain_timeout", 1000);
      tick();
      check("t2_frames", frame_starts.size() - base, 3);
      if (frame_starts.size() - base == 3) begin
         check("t2_gap01", frame_starts[base+1] - frame_starts[base], FRAME);
         check("t2_gap12", frame_starts[base+2] - frame_starts[base+1], FRAME);
      end

      // Overfill: A0 popped at once, A1..A4 buffered, A5 dropped
      wr_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_data = 8'hA0 + 8'(i);
         if (i < 5) exp_q.push_back(8'hA0 + 8'(i));
         tick();
      end
      wr_en = 1'b0;
      check("t3_count_full", count, 4);
      check("t3_full", full, 1);
      check("t3_overflow_set", overflow, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t3_overflow_clr", overflow, 0);
      wait_idle("t3_drain_timeout", 1000);
      tick();

      // Full FIFO with a write landing on the pop edge
      wr_en = 1'b1;
      wr_data = 8'hB0; exp_q.push_back(8'hB0); tick();
      for (int i = 1; i < 5; i++) begin
         wr_data = 8'hB0 + 8'(i);
         exp_q.push_back(8'hB0 + 8'(i));
         tick();
      end
      wr_en = 1'b0;
      check("t4_count_full", count, 4);
      check("t4_full", full, 1);
      repeat (FRAME - 4) tick();
      wr_en = 1'b1; wr_data = 8'hC5;
      tick();
      wr_en = 1'b0;
      check("t4_count_after_pop", count, 3);
      check("t4_overflow", overflow, 1);
      check("t4_not_full", full, 0);
      wait_idle("t4_drain_timeout", 1000);
      tick();

      // Reset mid-DATA of 0x3C with two bytes buffered; nothing of these is expected
      wr_en = 1'b1;
      wr_data = 8'h3C; tick();
      wr_data = 8'hD1; tick();
      wr_data = 8'hD2; tick();
      wr_en = 1'b0;
      check("t5_count_buffered", count, 2);
      repeat (DIV + 5) tick();
      #2;
      rstn = 1'b0;
      #1;
      check("t5_rst_tx", tx, 1);
      check("t5_rst_count", count, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_full", full, 0);
      check("t5_rst_overflow", overflow, 0);
      repeat (3) tick();
      rstn = 1'b1;
      low_seen = 1'b0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         if (tx == 1'b0) low_seen = 1'b1;
      end
      check("t5_quiet_after_rst", low_seen, 0);
      check("t5_busy_after_rst", busy, 0);
      wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
      tick();
      wr_en = 1'b0;
      wait_idle("t5_drain_timeout", 1000);
      repeat (3) tick();
      check("exp_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
